channel_isi_model: RTL and testbench
====================================

CHANNEL_ISI_MODEL -- requirements
Module: channel_isi_model

Interface
REQ-001 Parameter N_TAPS, default 4, number of FIR ISI taps (legal range 1..16).
REQ-002 Parameter DELAY, default 2, bulk channel delay in accepted samples (legal range 0..15).
REQ-003 Parameter A_POLE, default 0.9948 (real), IIR feedback coefficient.
REQ-004 Parameter B_GAIN, default 0.005222 (real), IIR input coefficient.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 in_valid  input  1  sample-enable; channel_in is accepted on a clk edge where in_valid=1.
REQ-008 channel_in  input  real  channel input sample u[n].
REQ-009 mode  input  2  00 bypass, 01 IIR, 10 FIR, 11 FIR->IIR cascade.
REQ-010 coef_wr  input  1  write coef_data into the shadow tap bank at coef_addr.
REQ-011 coef_addr  input  $clog2(N_TAPS) (min 1)  shadow tap index.
REQ-012 coef_data  input  real  tap value to write.
REQ-013 coef_commit  input  1  request copy of the shadow bank into the active bank.
REQ-014 coef_busy  output  1  high while a commit is in progress.
REQ-015 out_valid  output  1  channel_out is a settled, valid sample.
REQ-016 channel_out  output  real  filtered, delayed channel output.

Function
REQ-017 All state (history, IIR state, delay line, counters) SHALL advance only on edges where in_valid=1; with in_valid=0 all state and outputs hold.
REQ-018 Per accepted sample, the core result c SHALL be: bypass c=u[n]; FIR c=sum over k=0..N_TAPS-1 of h[k]*u[n-k]; IIR c=y[n]=B_GAIN*u[n-1]+A_POLE*y[n-1]; cascade applies IIR to the FIR result f[n] in place of u[n].
REQ-019 c SHALL be registered, then pass through DELAY further registered stages; channel_out is the output of the last stage, so an input that enters the core on accepted sample n reaches channel_out after DELAY+1 accepted samples.
REQ-020 History samples u[n-k] for k>=1 and y[n-1] SHALL be 0.0 after reset or a mode-change flush.
REQ-021 Warm-up counter SHALL count accepted samples, saturating at N_TAPS+DELAY+1; out_valid=1 only when the counter is saturated.
REQ-022 A change of mode SHALL be sampled on the next accepted sample, SHALL flush history, IIR state and delay line to 0.0 in that same cycle, and SHALL restart warm-up from 0; that sample is processed in the new mode with flushed history.
REQ-023 A coef_wr pulse SHALL update shadow[coef_addr] on the same edge; the active bank SHALL be unaffected.
REQ-024 Commit FSM states: IDLE, COPY. IDLE->COPY on coef_commit=1. COPY copies the whole shadow bank to the active bank in one cycle, then returns to IDLE. coef_busy=1 exactly in COPY.
REQ-025 coef_wr and coef_commit received while in COPY SHALL be ignored.
REQ-026 If coef_wr and coef_commit are asserted together in IDLE, the write SHALL land in shadow first and SHALL be included in the commit.
REQ-027 A commit SHALL NOT flush history or restart warm-up; taps take effect from the first accepted sample after COPY.
REQ-028 coef_addr >= N_TAPS SHALL cause the write to be dropped.

Reset
REQ-029 While rst=1, on each clk edge: channel_out=0.0, out_valid=0, coef_busy=0, FSM=IDLE, warm-up=0, history/IIR/delay=0.0.
REQ-030 rst SHALL reset the active and shadow banks to h[0]=1.0 and all other h[k]=0.0; rst overrides in_valid, coef_wr and coef_commit in the same cycle.
REQ-031 rst asserted mid-commit SHALL abort the COPY; the active bank takes its reset value.

Verification
REQ-032 Bypass, DELAY=2, in_valid=1, impulse 1.0 then 0.0 -> channel_out=1.0 exactly 3 edges after acceptance; out_valid rises after 7 accepted samples (N_TAPS=4).
REQ-033 IIR, constant input 1.0 -> the first nonzero core value is 0.005222; the output converges monotonically toward B_GAIN/(1-A_POLE)=1.00423 within 1e-3 after 2000 samples.
REQ-034 FIR, write taps {0.6,0.3,0.1,0.0} and commit, impulse 1.0 -> channel_out sequence 0.6, 0.3, 0.1, 0.0, with coef_busy high for exactly 1 cycle.
REQ-035 in_valid toggled 1,0,0,1 -> state and outputs hold during the 0 cycles; the output sequence is identical to the gapless stream.
REQ-036 Change mode from 10 to 01 mid-stream -> out_valid drops on the next accepted sample, the history reads 0.0, and out_valid returns after 7 accepted samples.
REQ-037 Assert rst while in COPY with the shadow bank = {0.5,...} -> after reset, a FIR impulse yields 1.0 (default taps), and coef_busy=0.

Source files
------------

// File: rtl/channel_isi_model.sv
// Behavioural channel model: optional FIR ISI, single-pole IIR low-pass, then a bulk delay.
// Taps are double-buffered: writes go to a shadow bank and a commit copies them into the active bank.
module channel_isi_model #(
   parameter int  N_TAPS = 4,
   parameter int  DELAY  = 2,
   parameter real A_POLE = 0.9948,
   parameter real B_GAIN = 0.005222,
   localparam int AW     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  real           channel_in,
   input  logic [1:0]    mode,
   input  logic          coef_wr,
   input  logic [AW-1:0] coef_addr,
   input  real           coef_data,
   input  logic          coef_commit,
   output logic          coef_busy,
   output logic          out_valid,
   output real           channel_out
);

   localparam int         DL       = (DELAY > 0) ? DELAY : 1;
   localparam logic [5:0] WARM_MAX = 6'(N_TAPS + DELAY + 1);
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_COPY  = 1'b1;

   real        hist_q   [N_TAPS];
   real        hist_d   [N_TAPS];
   real        shadow_q [N_TAPS];
   real        shadow_d [N_TAPS];
   real        active_q [N_TAPS];
   real        active_d [N_TAPS];
   real        dly_q    [DL];
   real        dly_d    [DL];
   real        x_prev_q, x_prev_d;
   real        y_prev_q, y_prev_d;
   real        core_q, core_d;
   logic [5:0] warm_q, warm_d;
   logic [1:0] mode_q, mode_d;
   logic [0:0] state_q, state_d;

   logic       flush;
   real        fir_acc;
   real        iir_y;
   real        x_cur;
   real        core_c;

   // A mode change only takes effect on an accepted sample; that sample sees all-zero history.
   always_comb begin
      flush   = in_valid && (mode != mode_q);
      fir_acc = active_q[0] * channel_in;
      for (int k = 1; k < N_TAPS; k++) begin
         fir_acc = fir_acc + active_q[k] * (flush ? 0.0 : hist_q[k-1]);
      end
      iir_y  = B_GAIN * (flush ? 0.0 : x_prev_q) + A_POLE * (flush ? 0.0 : y_prev_q);
      x_cur  = (mode == 2'b11) ? fir_acc : channel_in;
      case (mode)
         2'b00:   core_c = channel_in;
         2'b10:   core_c = fir_acc;
         default: core_c = iir_y;
      endcase

      hist_d   = hist_q;
      dly_d    = dly_q;
      x_prev_d = x_prev_q;
      y_prev_d = y_prev_q;
      core_d   = core_q;
      warm_d   = warm_q;
      mode_d   = mode_q;
      if (in_valid) begin
         hist_d[0] = channel_in;
         for (int k = 1; k < N_TAPS; k++) begin
            hist_d[k] = flush ? 0.0 : hist_q[k-1];
         end
         x_prev_d = x_cur;
         y_prev_d = iir_y;
         core_d   = core_c;
         dly_d[0] = flush ? 0.0 : core_q;
         for (int k = 1; k < DL; k++) begin
            dly_d[k] = flush ? 0.0 : dly_q[k-1];
         end
         if (flush) begin
            warm_d = 6'd1;
         end else if (warm_q != WARM_MAX) begin
            warm_d = warm_q + 6'd1;
         end
         mode_d = mode;
      end
   end

   // Commit path: a write in the same cycle as the commit lands first and is copied.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      state_d  = state_q;
      case (state_q)
         ST_IDLE: begin
            if (coef_wr && (int'(coef_addr) < N_TAPS)) begin
               shadow_d[coef_addr] = coef_data;
            end
            if (coef_commit) begin
               state_d = ST_COPY;
            end
         end
         default: begin
            active_d = shadow_q;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_TAPS; k++) begin
            hist_q[k]   <= 0.0;
            shadow_q[k] <= (k == 0) ? 1.0 : 0.0;
            active_q[k] <= (k == 0) ? 1.0 : 0.0;
         end
         for (int k = 0; k < DL; k++) begin
            dly_q[k] <= 0.0;
         end
         x_prev_q <= 0.0;
         y_prev_q <= 0.0;
         core_q   <= 0.0;
         warm_q   <= 6'd0;
         mode_q   <= 2'b00;
         state_q  <= ST_IDLE;
      end else begin
         hist_q   <= hist_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         dly_q    <= dly_d;
         x_prev_q <= x_prev_d;
         y_prev_q <= y_prev_d;
         core_q   <= core_d;
         warm_q   <= warm_d;
         mode_q   <= mode_d;
         state_q  <= state_d;
      end
   end

   assign channel_out = (DELAY == 0) ? core_q : dly_q[DL-1];
   assign out_valid   = (warm_q == WARM_MAX);
   assign coef_busy   = (state_q == ST_COPY);

endmodule

// File: tb/tb_channel_isi_model.sv
// Directed bench for channel_isi_model with a sample-history reference model checked every cycle.
module tb_channel_isi_model;

   localparam int  N_TAPS = 4;
   localparam int  DELAY  = 2;
   localparam real A_P    = 0.9948;
   localparam real B_G    = 0.005222;
   localparam int  W_MAX  = N_TAPS + DELAY + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   real        channel_in = 0.0;
   logic [1:0] mode = 2'b00;
   logic       coef_wr = 1'b0;
   logic [1:0] coef_addr = 2'd0;
   real        coef_data = 0.0;
   logic       coef_commit = 1'b0;
   logic       coef_busy;
   logic       out_valid;
   real        channel_out;

   channel_isi_model #(
      .N_TAPS(N_TAPS),
      .DELAY (DELAY),
      .A_POLE(A_P),
      .B_GAIN(B_G)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .channel_in (channel_in),
      .mode       (mode),
      .coef_wr    (coef_wr),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .coef_commit(coef_commit),
      .coef_busy  (coef_busy),
      .out_valid  (out_valid),
      .channel_out(channel_out)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_r(input string name, input real act, input real exp, input real tol);
      n_tests++;
      if (!((act - exp) <= tol && (exp - act) <= tol)) begin
         n_fail++;
         $display("FAIL %s: got %0.9f expected %0.9f", name, act, exp);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Reference model: keeps the accepted samples since the last flush and evaluates the
   // channel equations directly on that history.
   real        m_shadow [N_TAPS];
   real        m_active [N_TAPS];
   bit         m_copy;
   real        u_q[$];
   real        f_q[$];
   real        c_q[$];
   real        m_y;
   int         m_warm;
   logic [1:0] m_mode;
   real        m_out;
   bit         m_valid;
   bit         m_busy;
   bit         started = 1'b0;
   real        mf, mxp, my, mc;

   always @(posedge clk) begin
      started = 1'b1;
      if (rst) begin
         for (int k = 0; k < N_TAPS; k++) begin
            m_shadow[k] = (k == 0) ? 1.0 : 0.0;
            m_active[k] = (k == 0) ? 1.0 : 0.0;
         end
         m_copy = 1'b0;
         u_q.delete(); f_q.delete(); c_q.delete();
         m_y = 0.0; m_warm = 0; m_mode = 2'b00; m_out = 0.0;
      end else begin
         if (in_valid) begin
            if (mode != m_mode) begin
               u_q.delete(); f_q.delete(); c_q.delete();
               m_y = 0.0; m_warm = 0; m_mode = mode;
            end
            u_q.push_back(channel_in);
            mf = 0.0;
            for (int k = 0; k < N_TAPS; k++)
               if (u_q.size() > k) mf = mf + m_active[k] * u_q[u_q.size()-1-k];
               else                mf = mf + m_active[k] * 0.0;
            mxp = 0.0;
            if (mode == 2'b11) begin
               if (f_q.size() > 0) mxp = f_q[f_q.size()-1];
            end else if (u_q.size() > 1) begin
               mxp = u_q[u_q.size()-2];
            end
            my  = B_G * mxp + A_P * m_y;
            m_y = my;
            f_q.push_back(mf);
            case (mode)
               2'b00:   mc = channel_in;
               2'b10:   mc = mf;
               default: mc = my;
            endcase
            c_q.push_back(mc);
            if (m_warm < W_MAX) m_warm++;
         end
         if (m_copy) begin
            m_active = m_shadow;
            m_copy   = 1'b0;
         end else begin
            if (coef_wr && coef_addr < N_TAPS) m_shadow[coef_addr] = coef_data;
            if (coef_commit) m_copy = 1'b1;
         end
         m_out = (c_q.size() > DELAY) ? c_q[c_q.size()-1-DELAY] : 0.0;
      end
      m_valid = (m_warm == W_MAX);
      m_busy  = m_copy;
   end

   always @(negedge clk) begin
      if (started) begin
         check_r("model_out", channel_out, m_out, 1e-9);
         check_b("model_valid", out_valid, m_valid);
         check_b("model_busy", coef_busy, m_busy);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   real exp_fir [9];
   real gap_in  [6];
   logic gap_v  [6];
   real gap_exp [6];
   real prev;
   bit  mono_bad;

   initial begin
      exp_fir = '{0.0, 0.0, 0.0, 0.6, 0.3, 0.1, 0.0, 0.0, 0.0};
      gap_in  = '{1.0, 5.0, -3.0, 0.0, 0.0, 0.0};
      gap_v   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      gap_exp = '{0.0, 0.0, 0.0, 0.0, 0.6, 0.3};

      rst = 1'b1;
      tick(); tick();
      check_r("rst_out", channel_out, 0.0, 0.0);
      check_b("rst_valid", out_valid, 1'b0);
      check_b("rst_busy", coef_busy, 1'b0);

      // bypass impulse
      rst = 1'b0; mode = 2'b00; in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         channel_in = (i == 1) ? 1.0 : 0.0;
         tick();
         check_r("byp_out", channel_out, (i == 3) ? 1.0 : 0.0, 1e-12);
         check_b("byp_valid", out_valid, i >= 7);
      end

      // IIR step response
      mode = 2'b01; channel_in = 1.0; prev = 0.0; mono_bad = 1'b0;
      for (int i = 1; i <= 2000; i++) begin
         tick();
         if (i == 1) check_b("iir_flush_valid", out_valid, 1'b0);
         if (i == 4) check_r("iir_first", channel_out, 0.005222, 1e-12);
         if (channel_out < prev) mono_bad = 1'b1;
         prev = channel_out;
      end
      check_b("iir_mono", mono_bad, 1'b0);
      check_r("iir_conv", channel_out, 1.00423, 1e-3);

      // tap load; last write shares the commit cycle
      in_valid = 1'b0;
      coef_wr = 1'b1;
      coef_addr = 2'd0; coef_data = 0.6; tick();
      coef_addr = 2'd1; coef_data = 0.3; tick();
      coef_addr = 2'd3; coef_data = 0.0; tick();
      coef_addr = 2'd2; coef_data = 0.1; coef_commit = 1'b1; tick();
      check_b("commit_busy", coef_busy, 1'b1);
      coef_addr = 2'd0; coef_data = 9.0;
      tick();
      check_b("copy_done", coef_busy, 1'b0);
      coef_wr = 1'b0; coef_commit = 1'b0;
      tick();
      check_b("copy_ignored_commit", coef_busy, 1'b0);
      coef_wr = 1'b1; coef_addr = 2'd1; coef_data = 0.7; tick();
      coef_wr = 1'b0;

      // FIR impulse
      mode = 2'b10; in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         channel_in = (i == 1) ? 1.0 : 0.0;
         tick();
         check_r("fir_out", channel_out, exp_fir[i], 1e-12);
      end

      // sample-enable gaps
      for (int i = 0; i < 6; i++) begin
         in_valid = gap_v[i]; channel_in = gap_in[i];
         tick();
         check_r("gap_out", channel_out, gap_exp[i], 1e-12);
         check_b("gap_valid", out_valid, 1'b1);
      end

      // mode change mid-stream
      mode = 2'b01; in_valid = 1'b1; channel_in = 1.0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check_b("mc_valid", out_valid, i >= 7);
         if (i <= 3) check_r("mc_out", channel_out, 0.0, 0.0);
      end

      // reset during COPY
      in_valid = 1'b0;
      coef_wr = 1'b1; coef_addr = 2'd0; coef_data = 0.5; coef_commit = 1'b1;
      tick();
      coef_wr = 1'b0; coef_commit = 1'b0;
      check_b("abort_busy_pre", coef_busy, 1'b1);
      rst = 1'b1;
      tick();
      check_b("abort_busy", coef_busy, 1'b0);
      rst = 1'b0; mode = 2'b10; in_valid = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         channel_in = (i == 1) ? 1.0 : 0.0;
         tick();
         check_r("abort_fir", channel_out, (i == 3) ? 1.0 : 0.0, 1e-12);
         check_b("abort_busy_post", coef_busy, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
